// File: rtl/stream_arb2_if.sv
// ============================================================================
// Module   : stream_arb2_if
// Brief    : Valid/ready bundle between two sources, the arbiter and consumer.
//            Optional last signals exist only with STREAM_ARB2_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stream_arb2_if #(
    parameter int DATA_W = 8
);
    logic              a_valid;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              sel;
    logic              y_valid;
    logic [DATA_W-1:0] y_data;
    logic              y_src;
    logic              y_ready;
`ifdef STREAM_ARB2_LOCK_EN
    logic              a_last;
    logic              b_last;
    logic              y_last;
`endif

    // Environment side: drives both sources and the consumer ready.
    modport master (
`ifdef STREAM_ARB2_LOCK_EN
        output a_last, b_last,
        input  y_last,
`endif
        output a_valid, a_data, b_valid, b_data, y_ready,
        input  a_ready, b_ready, sel, y_valid, y_data, y_src
    );

    // Arbiter side.
    modport slave (
`ifdef STREAM_ARB2_LOCK_EN
        input  a_last, b_last,
        output y_last,
`endif
        input  a_valid, a_data, b_valid, b_data, y_ready,
        output a_ready, b_ready, sel, y_valid, y_data, y_src
    );
endinterface

`default_nettype wire

// File: rtl/stream_arb2.sv
// ============================================================================
// Module   : stream_arb2
// Brief    : Two-input round-robin valid/ready arbiter with output register.
//            Define STREAM_ARB2_LOCK_EN to hold a grant until the packet's last.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_arb2 #(
    parameter int DATA_W = 8
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    stream_arb2_if.slave bus
);

    logic              r_y_valid;
    logic [DATA_W-1:0] r_y_data;
    logic              r_y_src;
    logic              r_last_grant;
    logic              r_sel;

    logic              w_rr_sel;
    logic              w_sel;
    logic              w_load_en;
    logic              w_a_ready;
    logic              w_b_ready;
    logic              w_xfer;

    // Round-robin pick; with no requester the select line is left where it was.
    always_comb begin
        w_rr_sel = r_sel;
        case ({bus.a_valid, bus.b_valid})
            2'b10:   w_rr_sel = 1'b0;
            2'b01:   w_rr_sel = 1'b1;
            2'b11:   w_rr_sel = ~r_last_grant;
            default: w_rr_sel = r_sel;
        endcase
    end

`ifdef STREAM_ARB2_LOCK_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_y_last;
    logic   w_last;

    assign w_last = w_sel ? bus.b_last : bus.a_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel       = w_rr_sel;
        case (r_state)
            IDLE: begin
                if (w_xfer && !w_last) begin
                    w_state_nxt = w_sel ? LOCK_B : LOCK_A;
                end
            end
            LOCK_A: begin
                w_sel = 1'b0;
                if (w_xfer && w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            LOCK_B: begin
                w_sel = 1'b1;
                if (w_xfer && w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_last <= 1'b0;
        end else if (w_xfer) begin
            r_y_last <= w_last;
        end
    end

    assign bus.y_last = r_y_last;
`else
    assign w_sel = w_rr_sel;
`endif

    // Readies are gated by rst_n so nothing is accepted while reset is held.
    assign w_load_en = ~r_y_valid | bus.y_ready;
    assign w_a_ready = rst_n & w_load_en & ~w_sel;
    assign w_b_ready = rst_n & w_load_en &  w_sel;
    assign w_xfer    = (bus.a_valid & w_a_ready) | (bus.b_valid & w_b_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_valid    <= 1'b0;
            r_y_data     <= '0;
            r_y_src      <= 1'b0;
            r_last_grant <= 1'b1;
            r_sel        <= 1'b0;
        end else begin
            r_sel <= w_sel;
            if (w_xfer) begin
                r_y_valid    <= 1'b1;
                r_y_data     <= w_sel ? bus.b_data : bus.a_data;
                r_y_src      <= w_sel;
                r_last_grant <= w_sel;
            end else if (bus.y_ready) begin
                r_y_valid <= 1'b0;
            end
        end
    end

    assign bus.a_ready = w_a_ready;
    assign bus.b_ready = w_b_ready;
    assign bus.sel     = w_sel;
    assign bus.y_valid = r_y_valid;
    assign bus.y_data  = r_y_data;
    assign bus.y_src   = r_y_src;

endmodule

`default_nettype wire

// File: tb/tb_stream_arb2.sv
// ============================================================================
// Module   : tb_stream_arb2
// Brief    : Directed self-checking bench for stream_arb2 (lock tests only
//            with STREAM_ARB2_LOCK_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_arb2;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    stream_arb2_if #(.DATA_W(8)) bus ();

    stream_arb2 #(.DATA_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.a_valid = 1'b1;
        bus.a_data  = 8'hA1;
        bus.b_valid = 1'b1;
        bus.b_data  = 8'hB1;
        bus.y_ready = 1'b1;
`ifdef STREAM_ARB2_LOCK_EN
        bus.a_last = 1'b1;
        bus.b_last = 1'b1;
`endif

        // 1: reset with both sources requesting
        tick();
        tick();
        chk("rst_y_valid", {31'd0, bus.y_valid}, 32'd0);
        chk("rst_a_ready", {31'd0, bus.a_ready}, 32'd0);
        chk("rst_b_ready", {31'd0, bus.b_ready}, 32'd0);
        chk("rst_y_data",  {24'd0, bus.y_data},  32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_sel_a",   {31'd0, bus.sel},     32'd0);
        chk("rel_a_ready", {31'd0, bus.a_ready}, 32'd1);
        tick();
        chk("first_src",   {31'd0, bus.y_src},   32'd0);
        chk("first_data",  {24'd0, bus.y_data},  32'hA1);
        tick();
        chk("second_src",  {31'd0, bus.y_src},   32'd1);
        chk("second_data", {24'd0, bus.y_data},  32'hB1);

        // 2: only A valid, consecutive beats
        bus.b_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            bus.a_data = 8'(i * 8'h11);
            #1;
            chk("onlyA_b_ready", {31'd0, bus.b_ready}, 32'd0);
            tick();
            chk("onlyA_y_data",  {24'd0, bus.y_data},  32'(i * 8'h11));
            chk("onlyA_y_valid", {31'd0, bus.y_valid}, 32'd1);
        end

        // single B beat so that the next contention starts at A
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b1;
        bus.b_data  = 8'hBB;
        tick();
        chk("onlyB_src", {31'd0, bus.y_src}, 32'd1);

        // 3: both valid, strict alternation starting at A
        bus.a_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.a_data = 8'(8'h40 + i);
            bus.b_data = 8'(8'h80 + i);
            tick();
            chk("rr_src",  {31'd0, bus.y_src}, 32'(i % 2));
            chk("rr_data", {24'd0, bus.y_data}, (i % 2 == 0) ? 32'(8'h40 + i) : 32'(8'h80 + i));
        end

        // 4: stall with 0x5A held
        bus.b_valid = 1'b0;
        bus.a_data  = 8'h5A;
        tick();
        chk("stall_load", {24'd0, bus.y_data}, 32'h5A);
        bus.y_ready = 1'b0;
        bus.a_data  = 8'h66;
        bus.b_valid = 1'b1;
        bus.b_data  = 8'h77;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_a_ready", {31'd0, bus.a_ready}, 32'd0);
            chk("stall_b_ready", {31'd0, bus.b_ready}, 32'd0);
            tick();
            chk("stall_y_data",  {24'd0, bus.y_data},  32'h5A);
            chk("stall_y_valid", {31'd0, bus.y_valid}, 32'd1);
            chk("stall_y_src",   {31'd0, bus.y_src},   32'd0);
        end
        bus.y_ready = 1'b1;
        tick();
        chk("unstall_data", {24'd0, bus.y_data}, 32'h77);
        chk("unstall_src",  {31'd0, bus.y_src},  32'd1);

        // drain with no new request drops y_valid
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        tick();
        chk("drain_y_valid", {31'd0, bus.y_valid}, 32'd0);

        // 5: asynchronous reset while a beat is held
        bus.a_valid = 1'b1;
        bus.a_data  = 8'hC3;
        tick();
        chk("pre_rst_valid", {31'd0, bus.y_valid}, 32'd1);
        bus.b_valid = 1'b1;
        bus.b_data  = 8'hD4;
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_y_valid", {31'd0, bus.y_valid}, 32'd0);
        chk("async_a_ready", {31'd0, bus.a_ready}, 32'd0);
        chk("async_b_ready", {31'd0, bus.b_ready}, 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("restart_src",  {31'd0, bus.y_src},  32'd0);
        chk("restart_data", {24'd0, bus.y_data}, 32'hC3);

`ifdef STREAM_ARB2_LOCK_EN
        // 6: 3-beat A packet while B waits, then B gets the next grant
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        bus.b_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.a_data = 8'(8'hE0 + i);
            bus.a_last = (i == 2);
            #1;
            chk("lock_b_ready", {31'd0, bus.b_ready}, 32'd0);
            tick();
            chk("lock_src",    {31'd0, bus.y_src},  32'd0);
            chk("lock_data",   {24'd0, bus.y_data}, 32'(8'hE0 + i));
            chk("lock_y_last", {31'd0, bus.y_last}, (i == 2) ? 32'd1 : 32'd0);
        end
        tick();
        chk("after_pkt_src",  {31'd0, bus.y_src},  32'd1);
        chk("after_pkt_last", {31'd0, bus.y_last}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
